// File: rtl/scs8hd_ebufn_pkg.sv
// Shared definitions for the ebufn bus controller: FSM state encoding,
// legal ranges of the TURN / MAX_BURST parameters and the pointer width.
package scs8hd_ebufn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  localparam int TURN_MAX      = 3;
  localparam int MAX_BURST_MIN = 2;
  localparam int MAX_BURST_MAX = 255;

  // Width of the round-robin pointer / owner index; never narrower than 1.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scs8hd_ebufn_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping at NCH. Returns a one-hot winner, its index and a valid flag.
module scs8hd_ebufn_rr_arb
  import scs8hd_ebufn_pkg::*;
#(
  parameter int NCH = 4,
  localparam int PW = ptr_width(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [NCH-1:0] win,
  output logic [PW-1:0]  win_idx,
  output logic           valid
);

  int idx;

  // Scan channels starting at the pointer; the first hit wins.
  always_comb begin
    win     = '0;
    win_idx = '0;
    valid   = 1'b0;
    idx     = 0;
    for (int off = 0; off < NCH; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NCH) idx = idx - NCH;
      if (!valid && req[PW'(idx)]) begin
        valid            = 1'b1;
        win[PW'(idx)]    = 1'b1;
        win_idx          = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/scs8hd_ebufn_bus_ctl.sv
// Clocked, arbitrated successor of the inverted-enable tri-state buffer.
// NCH requesters share one WIDTH-bit tri-state bus, with TURN dead cycles
// between owners and a MAX_BURST limit while others wait.
// Optional feature macro: SCS8HD_EBUFN_KEEPER_EN (bus keeper holds the last
// driven value instead of floating).
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | bus released, arbitrate among requesters each cycle
// ST_DRIVE | one owner drives Z from the data register
// ST_TURN  | dead time after release, all TEB high, counts TURN cycles
module scs8hd_ebufn_bus_ctl
  import scs8hd_ebufn_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NCH       = 4,
  parameter int TURN      = 1,
  parameter int MAX_BURST = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NCH-1:0]       REQ,
  input  logic [NCH*WIDTH-1:0] A,
  output logic [NCH-1:0]       GNT,
  output logic [NCH-1:0]       TEB,
  output tri   [WIDTH-1:0]     Z,
  output logic                 BUSY
);

  localparam int PW     = ptr_width(NCH);
  localparam int TURN_C = (TURN > TURN_MAX) ? TURN_MAX : ((TURN < 0) ? 0 : TURN);
  localparam int MB_C   = (MAX_BURST > MAX_BURST_MAX) ? MAX_BURST_MAX :
                          ((MAX_BURST < MAX_BURST_MIN) ? MAX_BURST_MIN : MAX_BURST);
  localparam logic [7:0] MB      = 8'(MB_C);
  localparam logic [1:0] TURN_LD = 2'((TURN_C > 0) ? TURN_C - 1 : 0);

  state_t           state_q, state_d;
  logic [NCH-1:0]   gnt_q, gnt_d, win;
  logic [PW-1:0]    own_q, own_d, ptr_q, ptr_d, win_idx, sel_idx;
  logic [7:0]       burst_q, burst_d, burst_inc;
  logic [1:0]       turn_q, turn_d;
  logic [WIDTH-1:0] data_q, a_sel;
  logic             valid, load, others;

  scs8hd_ebufn_rr_arb #(.NCH(NCH)) u_arb (
    .req     (REQ),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx),
    .valid   (valid)
  );

  // Pick the channel whose data is loaded: the new winner in IDLE, else the owner.
  always_comb begin
    sel_idx = (state_q == ST_IDLE) ? win_idx : own_q;
    a_sel   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel_idx == PW'(i)) a_sel = A[i*WIDTH +: WIDTH];
    end
  end

  // Next-state logic: grant, burst limiting, release and turnaround timing.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    own_d     = own_q;
    ptr_d     = ptr_q;
    burst_d   = burst_q;
    turn_d    = turn_q;
    load      = 1'b0;
    others    = |(REQ & ~gnt_q);
    burst_inc = (burst_q >= MB) ? MB : burst_q + 8'd1;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          state_d = ST_DRIVE;
          gnt_d   = win;
          own_d   = win_idx;
          ptr_d   = (win_idx == PW'(NCH-1)) ? '0 : win_idx + PW'(1);
          burst_d = '0;
          load    = 1'b1;
        end
      end
      ST_DRIVE: begin
        // Owner drop and forced release share one exit path.
        if (!REQ[own_q] || (burst_inc == MB && others)) begin
          gnt_d = '0;
          if (TURN_C == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_TURN;
            turn_d  = TURN_LD;
          end
        end else begin
          burst_d = burst_inc;
          load    = 1'b1;
        end
      end
      ST_TURN: begin
        if (turn_q == 2'd0) state_d = ST_IDLE;
        else                turn_d  = turn_q - 2'd1;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset releases the bus on the same edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      own_q   <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
      turn_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      turn_q  <= turn_d;
      if (load) data_q <= a_sel;
    end
  end

  assign GNT  = gnt_q;
  assign TEB  = ~gnt_q;
  assign BUSY = (state_q != ST_IDLE);

`ifdef SCS8HD_EBUFN_KEEPER_EN
  // data_q only loads while driving, so it is also the keeper's held value.
  assign Z = data_q;
`else
  // Inverted-enable drivers: the owner's TEB low enables the whole bus.
  logic drv_off;
  assign drv_off = TEB[own_q];
  assign Z = drv_off ? {WIDTH{1'bz}} : data_q;
`endif

endmodule

// File: tb/tb_scs8hd_ebufn_bus_ctl.sv
// Self-checking bench for scs8hd_ebufn_bus_ctl (NCH=4, WIDTH=8, TURN=1,
// MAX_BURST=4). Honours SCS8HD_EBUFN_KEEPER_EN for released-bus values.
module tb_scs8hd_ebufn_bus_ctl;

  localparam int TB_TURN = 1;
  localparam int TB_MB   = 4;
`ifdef SCS8HD_EBUFN_KEEPER_EN
  localparam bit KEEP = 1'b1;
`else
  localparam bit KEEP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] a;
  logic [3:0]  gnt, teb;
  tri   [7:0]  z_bus;
  logic        busy;
  logic [7:0]  keep_exp;

  int n_checks = 0;
  int n_pass   = 0;

  wire z_is_hiz = (z_bus === 8'hzz);
  wire bus_off  = KEEP ? (z_bus === keep_exp) : z_is_hiz;

  scs8hd_ebufn_bus_ctl #(.WIDTH(8), .NCH(4), .TURN(TB_TURN), .MAX_BURST(TB_MB)) dut (
    .CLK(clk), .RESET(rst), .REQ(req), .A(a),
    .GNT(gnt), .TEB(teb), .Z(z_bus), .BUSY(busy)
  );

  always #5 clk = ~clk;

  // Never more than one driver enabled.
  always @(negedge clk) begin
    n_checks++;
    if ($countones(~teb) > 1) $display("FAIL contention: teb=%b", teb);
    else n_pass++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0;
    step(); step();
    rst = 1'b0; keep_exp = 8'h00;
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; a = 32'hDEADBEEF; keep_exp = 8'h00;
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else n_pass++;
      n_checks++; if (teb !== 4'b1111) $display("FAIL reset_teb: got %b want 1111", teb); else n_pass++;
      n_checks++; if (bus_off !== 1'b1) $display("FAIL reset_z: got %h want released", z_bus); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    end
    rst = 1'b0; req = '0;
  endtask

  task automatic test_single();
    a = '0; a[23:16] = 8'hA5; req = 4'b0100;
    step();
    n_checks++; if (gnt !== 4'b0100) $display("FAIL single_gnt: got %b want 0100", gnt); else n_pass++;
    n_checks++; if (teb !== 4'b1011) $display("FAIL single_teb: got %b want 1011", teb); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
    n_checks++; if (z_bus !== 8'hA5) $display("FAIL single_z0: got %h want a5", z_bus); else n_pass++;
    a[23:16] = 8'h5A;
    step();
    n_checks++; if (z_bus !== 8'h5A) $display("FAIL single_z1: got %h want 5a", z_bus); else n_pass++;
    req = 4'b0000;
    step();
    keep_exp = 8'h5A;
    n_checks++; if (teb !== 4'b1111) $display("FAIL single_rel_teb: got %b want 1111", teb); else n_pass++;
    n_checks++; if (bus_off !== 1'b1) $display("FAIL single_rel_z: got %h want released", z_bus); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL single_turn_busy: got %b want 1", busy); else n_pass++;
    step();
    n_checks++; if (busy !== 1'b0) $display("FAIL single_idle_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (bus_off !== 1'b1) $display("FAIL single_idle_z: got %h want released", z_bus); else n_pass++;
  endtask

  task automatic test_round_robin();
    int gap, budget, o;
    do_reset();
    for (int i = 0; i < 4; i++) a[i*8 +: 8] = 8'h10 + 8'(i);
    req = 4'b1111; gap = 0;
    for (int k = 0; k < 5; k++) begin
      o = k % 4; budget = 12;
      while (gnt === 4'b0000 && budget > 0) begin
        step(); budget--;
        if (gnt === 4'b0000) begin
          gap++;
          n_checks++; if (bus_off !== 1'b1) $display("FAIL rr_gap_z: got %h want released", z_bus); else n_pass++;
        end
      end
      n_checks++; if (budget == 0) $display("FAIL rr_timeout: owner %0d budget left %0d want >0", o, budget); else n_pass++;
      n_checks++; if (gnt !== (4'b0001 << o)) $display("FAIL rr_order: got %b want %b", gnt, 4'b0001 << o); else n_pass++;
      if (k > 0) begin
        n_checks++; if (gap != TB_TURN + 1) $display("FAIL rr_gap: got %0d want %0d", gap, TB_TURN + 1); else n_pass++;
      end
      for (int c = 0; c < 3; c++) begin
        if (c > 0) step();
        n_checks++; if (z_bus !== 8'h10 + 8'(o)) $display("FAIL rr_z: got %h want %h", z_bus, 8'h10 + 8'(o)); else n_pass++;
      end
      req[o] = 1'b0;
      step();
      keep_exp = 8'h10 + 8'(o);
      n_checks++; if (gnt !== 4'b0000) $display("FAIL rr_release: got %b want 0000", gnt); else n_pass++;
      gap = 1;
      req[o] = 1'b1;
    end
    req = '0;
    step(); step(); step();
  endtask

  task automatic test_forced();
    int drive, budget, held;
    do_reset();
    a = '0; a[7:0] = 8'h11; a[15:8] = 8'h22;
    req = 4'b0001;
    step();
    n_checks++; if (gnt !== 4'b0001) $display("FAIL forced_gnt0: got %b want 0001", gnt); else n_pass++;
    req[1] = 1'b1; drive = 1; budget = 10;
    while (gnt === 4'b0001 && budget > 0) begin
      step(); budget--;
      if (gnt === 4'b0001) drive++;
    end
    n_checks++; if (drive != TB_MB) $display("FAIL forced_len: got %0d want %0d", drive, TB_MB); else n_pass++;
    budget = 10;
    while (gnt === 4'b0000 && budget > 0) begin step(); budget--; end
    n_checks++; if (gnt !== 4'b0010) $display("FAIL forced_next: got %b want 0010", gnt); else n_pass++;
    req = '0;
    step(); step(); step();
    do_reset();
    req = 4'b0001; held = 0;
    step();
    for (int c = 0; c < 50; c++) begin
      step();
      if (gnt === 4'b0001) held++;
    end
    n_checks++; if (held != 50) $display("FAIL lone_hold: got %0d want 50", held); else n_pass++;
    req[2] = 1'b1;
    step();
    n_checks++; if (gnt !== 4'b0000) $display("FAIL lone_forced: got %b want 0000", gnt); else n_pass++;
    req = '0;
    step(); step(); step();
  endtask

  task automatic test_reset_mid_drive();
    do_reset();
    a = '0; a[31:24] = 8'h3C; req = 4'b1000;
    step();
    n_checks++; if (gnt !== 4'b1000) $display("FAIL mid_gnt: got %b want 1000", gnt); else n_pass++;
    step();
    n_checks++; if (z_bus !== 8'h3C) $display("FAIL mid_z: got %h want 3c", z_bus); else n_pass++;
    rst = 1'b1; req = 4'b1111;
    step();
    keep_exp = 8'h00;
    n_checks++; if (teb !== 4'b1111) $display("FAIL mid_teb: got %b want 1111", teb); else n_pass++;
    n_checks++; if (bus_off !== 1'b1) $display("FAIL mid_zrel: got %h want released", z_bus); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
    rst = 1'b0; req = 4'b0010;
    step();
    n_checks++; if (gnt !== 4'b0010) $display("FAIL mid_gnt1: got %b want 0010", gnt); else n_pass++;
    req = 4'b1111;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    n_checks++; if (gnt !== 4'b0001) $display("FAIL mid_ptr: got %b want 0001", gnt); else n_pass++;
    req = '0;
    step(); step(); step();
  endtask

  task automatic test_random();
    logic [31:0] sb[$];
    logic [31:0] snap;
    logic [3:0]  prev_req, prev_gnt;
    int          gap, o, p;
    do_reset();
    gap = 100; prev_gnt = '0;
    a = $urandom; req = 4'($urandom_range(0, 15));
    sb.push_back(a); prev_req = req;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      step();
      snap = sb.pop_front();
      n_checks++;
      if (teb !== ~gnt || $countones(gnt) > 1) $display("FAIL rnd_onehot: gnt=%b teb=%b", gnt, teb);
      else n_pass++;
      if (prev_gnt != 4'b0000) begin
        p = oh_idx(prev_gnt);
        if (!prev_req[p]) begin
          n_checks++; if (gnt[p] !== 1'b0) $display("FAIL rnd_release: ch %0d gnt=%b want bit clear", p, gnt); else n_pass++;
        end
      end
      if (gnt != 4'b0000) begin
        o = oh_idx(gnt);
        n_checks++; if (z_bus !== snap[o*8 +: 8]) $display("FAIL rnd_z: cyc %0d got %h want %h", cyc, z_bus, snap[o*8 +: 8]); else n_pass++;
        keep_exp = snap[o*8 +: 8];
        if (prev_gnt == 4'b0000) begin
          n_checks++; if (gap < TB_TURN + 1) $display("FAIL rnd_gap: got %0d want >=%0d", gap, TB_TURN + 1); else n_pass++;
        end else begin
          n_checks++; if (gnt !== prev_gnt) $display("FAIL rnd_switch: got %b want %b", gnt, prev_gnt); else n_pass++;
        end
        gap = 0;
      end else begin
        gap++;
        n_checks++; if (bus_off !== 1'b1) $display("FAIL rnd_zrel: cyc %0d got %h want released", cyc, z_bus); else n_pass++;
      end
      prev_gnt = gnt;
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
      a = $urandom;
      sb.push_back(a); prev_req = req;
    end
    req = '0;
    step(); step(); step();
  endtask

  initial begin
    rst = 1'b1; req = '0; a = '0; keep_exp = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_forced();
    test_reset_mid_drive();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
